// File: rtl/wb_timeout_bridge.sv
// Registered Wishbone bridge that guarantees every accepted request terminates:
// a slave that never acks is answered by the bridge itself with an error ack.
module wb_timeout_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // Upstream master
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    // Downstream slave
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i,
    // Status
    output logic        err_o,
    output logic [7:0]  timeout_count_o
);

    typedef enum logic [1:0] {StIdle, StFwd, StResp} state_e;

    localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

    state_e      state_q;
    logic [15:0] wait_q;
    logic [15:0] wait_inc;
    logic        wbs_ack_q;
    logic [31:0] wbs_dat_q;
    logic        m_cyc_q;
    logic        m_stb_q;
    logic        m_we_q;
    logic [3:0]  m_sel_q;
    logic [31:0] m_adr_q;
    logic [31:0] m_dat_q;
    logic        err_q;
    logic [7:0]  timeout_count_q;

    assign wait_inc = wait_q + 16'd1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q         <= StIdle;
            wait_q          <= 16'd0;
            wbs_ack_q       <= 1'b0;
            wbs_dat_q       <= 32'd0;
            m_cyc_q         <= 1'b0;
            m_stb_q         <= 1'b0;
            m_we_q          <= 1'b0;
            m_sel_q         <= 4'd0;
            m_adr_q         <= 32'd0;
            m_dat_q         <= 32'd0;
            err_q           <= 1'b0;
            timeout_count_q <= 8'd0;
        end else begin
            // Response strobes are single-cycle; only the FWD exit raises them.
            wbs_ack_q <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        m_cyc_q <= 1'b1;
                        m_stb_q <= 1'b1;
                        m_we_q  <= wbs_we_i;
                        m_sel_q <= wbs_sel_i;
                        m_adr_q <= wbs_adr_i;
                        m_dat_q <= wbs_dat_i;
                        wait_q  <= 16'd0;
                        state_q <= StFwd;
                    end
                end
                StFwd: begin
                    if (!wbs_cyc_i) begin
                        // Master gave up: release the slave silently.
                        m_cyc_q <= 1'b0;
                        m_stb_q <= 1'b0;
                        state_q <= StIdle;
                    end else if (m_ack_i) begin
                        m_cyc_q   <= 1'b0;
                        m_stb_q   <= 1'b0;
                        wbs_dat_q <= m_dat_i;
                        wbs_ack_q <= 1'b1;
                        state_q   <= StResp;
                    end else begin
                        wait_q <= wait_inc;
                        if (wait_inc == TimeoutLimit) begin
                            m_cyc_q   <= 1'b0;
                            m_stb_q   <= 1'b0;
                            wbs_dat_q <= ERR_DATA;
                            wbs_ack_q <= 1'b1;
                            err_q     <= 1'b1;
                            if (timeout_count_q != 8'hFF) begin
                                timeout_count_q <= timeout_count_q + 8'd1;
                            end
                            state_q   <= StResp;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign wbs_ack_o       = wbs_ack_q;
    assign wbs_dat_o       = wbs_dat_q;
    assign m_cyc_o         = m_cyc_q;
    assign m_stb_o         = m_stb_q;
    assign m_we_o          = m_we_q;
    assign m_sel_o         = m_sel_q;
    assign m_adr_o         = m_adr_q;
    assign m_dat_o         = m_dat_q;
    assign err_o           = err_q;
    assign timeout_count_o = timeout_count_q;

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Bench for wb_timeout_bridge: directed and randomized transactions scored against a
// per-transaction outcome model (ack / timeout / abort) derived from the bridge rules.
module tb_wb_timeout_bridge;

    localparam int          T       = 8;
    localparam logic [31:0] ErrData = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_adr, wbs_dat;
    logic        wbs_ack;
    logic [31:0] wbs_rdat;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat;
    logic        m_ack;
    logic [31:0] m_rdat;
    logic        err;
    logic [7:0]  tcount;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_dat = 32'd0;
    int          model_cnt = 0;

    always #5 clk = ~clk;

    wb_timeout_bridge #(
        .TIMEOUT_CYCLES(T),
        .ERR_DATA      (ErrData)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs_cyc_i      (wbs_cyc),
        .wbs_stb_i      (wbs_stb),
        .wbs_we_i       (wbs_we),
        .wbs_sel_i      (wbs_sel),
        .wbs_adr_i      (wbs_adr),
        .wbs_dat_i      (wbs_dat),
        .wbs_ack_o      (wbs_ack),
        .wbs_dat_o      (wbs_rdat),
        .m_cyc_o        (m_cyc),
        .m_stb_o        (m_stb),
        .m_we_o         (m_we),
        .m_sel_o        (m_sel),
        .m_adr_o        (m_adr),
        .m_dat_o        (m_dat),
        .m_ack_i        (m_ack),
        .m_dat_i        (m_rdat),
        .err_o          (err),
        .timeout_count_o(tcount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_reset();
        chk("rst_wbs_ack", 32'(wbs_ack), 32'd0);
        chk("rst_wbs_dat", wbs_rdat, 32'd0);
        chk("rst_m_cyc", 32'(m_cyc), 32'd0);
        chk("rst_m_stb", 32'(m_stb), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_m_sel", 32'(m_sel), 32'd0);
        chk("rst_m_adr", m_adr, 32'd0);
        chk("rst_m_dat", m_dat, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(tcount), 32'd0);
    endtask

    // Called at a negedge with the bridge idle. ack_at: FWD cycle (0 = first cycle with
    // m_stb_o high) in which the slave acks; abort_at: FWD cycle in which cyc drops (-1 none).
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int ack_at, input int abort_at,
                       input logic [31:0] sdat, input bit hold_resp);
        int e;
        bit is_ab;
        bit is_to;
        bit cyc;
        e     = T - 1;
        is_to = 1'b1;
        is_ab = 1'b0;
        if (ack_at < T) begin
            e     = ack_at;
            is_to = 1'b0;
        end
        if (abort_at >= 0 && abort_at <= e) begin
            e     = abort_at;
            is_ab = 1'b1;
            is_to = 1'b0;
        end
        if (is_to && model_cnt < 255) model_cnt++;
        wbs_cyc = 1'b1;
        wbs_stb = 1'b1;
        wbs_we  = we;
        wbs_adr = adr;
        wbs_dat = dat;
        wbs_sel = sel;
        m_rdat  = sdat;
        for (int i = 0; i <= e + 2; i++) begin
            @(negedge clk);
            if (i <= e) begin
                chk("fwd_m_stb", 32'(m_stb), 32'd1);
                chk("fwd_m_cyc", 32'(m_cyc), 32'd1);
                chk("fwd_m_adr", m_adr, adr);
                chk("fwd_m_dat", m_dat, dat);
                chk("fwd_m_sel", 32'(m_sel), 32'(sel));
                chk("fwd_m_we", 32'(m_we), 32'(we));
                chk("fwd_wbs_ack", 32'(wbs_ack), 32'd0);
                chk("fwd_err", 32'(err), 32'd0);
            end else if (i == e + 1) begin
                if (!is_ab) model_dat = is_to ? ErrData : sdat;
                chk("end_m_stb", 32'(m_stb), 32'd0);
                chk("end_m_cyc", 32'(m_cyc), 32'd0);
                chk("end_wbs_ack", 32'(wbs_ack), 32'(!is_ab));
                chk("end_err", 32'(err), 32'(is_to));
            end else begin
                chk("post_m_stb", 32'(m_stb), 32'd0);
                chk("post_wbs_ack", 32'(wbs_ack), 32'd0);
                chk("post_err", 32'(err), 32'd0);
            end
            chk("wbs_dat", wbs_rdat, model_dat);
            m_ack = (i == ack_at);
            cyc   = (i <= e) && !(abort_at >= 0 && i >= abort_at);
            if (i == e + 1 && hold_resp && !is_ab) cyc = 1'b1;
            wbs_cyc = cyc;
            wbs_stb = cyc;
        end
        chk("count", 32'(tcount), 32'(model_cnt));
    endtask

    initial begin
        rst     = 1'b1;
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        wbs_we  = 1'b0;
        wbs_sel = 4'd0;
        wbs_adr = 32'd0;
        wbs_dat = 32'd0;
        m_ack   = 1'b0;
        m_rdat  = 32'd0;
        repeat (3) @(negedge clk);
        chk_outputs_reset();
        rst = 1'b0;
        @(negedge clk);

        // Directed: normal read, write timeout, ack on the timeout cycle, abort with late ack.
        txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 2, -1, 32'h1234_5678, 1'b0);
        txn(1'b1, 32'h3000_0010, 32'hA5A5_0001, 4'b0011, 1000, -1, 32'h5555_AAAA, 1'b0);
        txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, T - 1, -1, 32'hCAFE_F00D, 1'b0);
        txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 4, 3, 32'h0BAD_0BAD, 1'b0);
        txn(1'b0, 32'h3000_0034, 32'h0, 4'hF, 0, -1, 32'h0000_0001, 1'b1);

        for (int n = 0; n < 60; n++) begin
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, T + 2)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T)) : -1,
                $urandom, 1'($urandom_range(0, 1)));
        end

        // Drive the timeout counter well past saturation.
        for (int n = 0; n < 300; n++) begin
            txn(1'b0, $urandom, $urandom, 4'hF, 1000, -1, $urandom, 1'b0);
        end
        chk("count_saturated", 32'(tcount), 32'hFF);

        // Reset during FWD, with a slave ack landing in the reset cycle.
        wbs_cyc = 1'b1;
        wbs_stb = 1'b1;
        wbs_adr = 32'h3000_0040;
        @(negedge clk);
        chk("pre_rst_m_stb", 32'(m_stb), 32'd1);
        rst   = 1'b1;
        m_ack = 1'b1;
        @(negedge clk);
        chk_outputs_reset();
        rst       = 1'b0;
        m_ack     = 1'b0;
        wbs_cyc   = 1'b0;
        wbs_stb   = 1'b0;
        model_dat = 32'd0;
        model_cnt = 0;
        @(negedge clk);
        chk("post_rst_wbs_ack", 32'(wbs_ack), 32'd0);
        chk("post_rst_m_stb", 32'(m_stb), 32'd0);
        txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, -1, 32'h8765_4321, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
